// File: rtl/deser_fila_pkg.sv
// Shared types and helpers for the deserializer + circular queue (deser_fila_param).
// DESER_PARITY_EN adds the parity-check state to the FSM encoding.
package deser_fila_pkg;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_PUSH    = 2'd1
`ifdef DESER_PARITY_EN
        ,
        S_PARITY  = 2'd2
`endif
    } state_t;

    // Occupancy runs 0..depth inclusive, so it needs one more code than a pointer.
    function automatic int len_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fila_sync.sv
// Synchronous circular queue with first-word-fall-through head and occupancy count.
// A push while full is only honoured together with a pop, so no word is ever overwritten.
module fila_sync
    import deser_fila_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [len_w(DEPTH)-1:0]  len,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = len_w(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (len == LEN_MAX);
    assign empty   = (len == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            len    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   len <= len + LEN_ONE;
                2'b01:   len <= len - LEN_ONE;
                default: len <= len;
            endcase
        end
    end

endmodule

// File: rtl/deser_fila_param.sv
// LSB-first serial-to-parallel deserializer feeding a DEPTH-entry circular queue.
// Optional DESER_PARITY_EN: an even-parity bit follows each word; bad words are dropped.
//
// state     | meaning
// S_COLLECT | shifting serial bits into the word, bit_cnt = next position
// S_PARITY  | word complete, waiting for its parity bit (DESER_PARITY_EN only)
// S_PUSH    | word complete, waiting for queue space; serial input ignored
module deser_fila_param
    import deser_fila_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                     clk_1MHz,
    input  logic                     reset,
    input  logic                     data_in,
    input  logic                     write_in,
    input  logic                     dequeue_in,
    output logic [DATA_W-1:0]        fila_data_out,
    output logic [len_w(DEPTH)-1:0]  fila_len_out,
    output logic                     status_out,
`ifdef DESER_PARITY_EN
    output logic                     parity_err_out,
`endif
    output logic                     full_out,
    output logic                     empty_out,
    output logic                     almost_full_out
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam int LEN_W = len_w(DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [LEN_W-1:0] AF_CNT   = LEN_W'(AF_LEVEL);

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_cnt;
    logic              push;

    // At full the pending word goes in on the same edge the consumer frees a slot.
    assign push            = (state == S_PUSH) && (!full_out || dequeue_in);
    assign status_out      = (state == S_PUSH) && full_out;
    assign almost_full_out = (fila_len_out >= AF_CNT);

    fila_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fila (
        .clk   (clk_1MHz),
        .reset (reset),
        .push  (push),
        .pop   (dequeue_in),
        .din   (shift_reg),
        .dout  (fila_data_out),
        .len   (fila_len_out),
        .full  (full_out),
        .empty (empty_out)
    );

    always_ff @(posedge clk_1MHz) begin
        if (reset) begin
            state     <= S_COLLECT;
            shift_reg <= '0;
            bit_cnt   <= '0;
`ifdef DESER_PARITY_EN
            parity_err_out <= 1'b0;
`endif
        end else begin
`ifdef DESER_PARITY_EN
            parity_err_out <= 1'b0;
`endif
            case (state)
                S_COLLECT: begin
                    if (write_in) begin
                        shift_reg[bit_cnt] <= data_in;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef DESER_PARITY_EN
                            state   <= S_PARITY;
`else
                            state   <= S_PUSH;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end
                end
`ifdef DESER_PARITY_EN
                S_PARITY: begin
                    if (write_in) begin
                        if ((^shift_reg) == data_in) begin
                            state <= S_PUSH;
                        end else begin
                            state          <= S_COLLECT;
                            parity_err_out <= 1'b1;
                        end
                    end
                end
`endif
                S_PUSH: begin
                    if (push) begin
                        state <= S_COLLECT;
                    end
                end
                default: state <= S_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_deser_fila_param.sv
// Directed bench for deser_fila_param: default 8/8/7 instance plus a 16/4/3 instance.
// Parity steps are built only when DESER_PARITY_EN is defined.
module tb_deser_fila_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_asserts = 0;
    int   n_fail    = 0;

    logic        a_data, a_write, a_deq;
    logic [7:0]  a_dout;
    logic [3:0]  a_len;
    logic        a_status, a_full, a_empty, a_af;

    logic        b_data, b_write, b_deq;
    logic [15:0] b_dout;
    logic [2:0]  b_len;
    logic        b_status, b_full, b_empty, b_af;

`ifdef DESER_PARITY_EN
    logic        a_perr, b_perr;
`endif

    deser_fila_param dut_a (
        .clk_1MHz        (clk),
        .reset           (reset),
        .data_in         (a_data),
        .write_in        (a_write),
        .dequeue_in      (a_deq),
        .fila_data_out   (a_dout),
        .fila_len_out    (a_len),
        .status_out      (a_status),
`ifdef DESER_PARITY_EN
        .parity_err_out  (a_perr),
`endif
        .full_out        (a_full),
        .empty_out       (a_empty),
        .almost_full_out (a_af)
    );

    deser_fila_param #(.DATA_W(16), .DEPTH(4), .AF_LEVEL(3)) dut_b (
        .clk_1MHz        (clk),
        .reset           (reset),
        .data_in         (b_data),
        .write_in        (b_write),
        .dequeue_in      (b_deq),
        .fila_data_out   (b_dout),
        .fila_len_out    (b_len),
        .status_out      (b_status),
`ifdef DESER_PARITY_EN
        .parity_err_out  (b_perr),
`endif
        .full_out        (b_full),
        .empty_out       (b_empty),
        .almost_full_out (b_af)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input int sel, input logic d, input logic w, input logic q);
        if (sel == 0) begin
            a_data = d; a_write = w; a_deq = q;
        end else begin
            b_data = d; b_write = w; b_deq = q;
        end
    endtask

    // One bit every other cycle; optional dequeue on the idle cycle after the last bit.
    task automatic send_bits(input int sel, input logic [15:0] v, input int n, input logic pop_last);
        for (int i = 0; i < n; i++) begin
            drive(sel, v[i], 1'b1, 1'b0);
            cyc();
            drive(sel, 1'b0, 1'b0, pop_last && (i == n - 1));
            cyc();
        end
        drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input int sel, input logic [15:0] v, input int n, input logic pop_at_push);
`ifdef DESER_PARITY_EN
        logic [15:0] par;
        par = {15'b0, ^v};
        send_bits(sel, v, n, 1'b0);
        send_bits(sel, par, 1, pop_at_push);
`else
        send_bits(sel, v, n, pop_at_push);
`endif
    endtask

    task automatic pop(input int sel);
        drive(sel, 1'b0, 1'b0, 1'b1);
        cyc();
        drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        reset = 1'b0;
        cyc();

        chk("rst_a_data",   a_dout,   0);
        chk("rst_a_len",    a_len,    0);
        chk("rst_a_status", a_status, 0);
        chk("rst_a_full",   a_full,   0);
        chk("rst_a_empty",  a_empty,  1);
        chk("rst_a_af",     a_af,     0);
        chk("rst_b_data",   b_dout,   0);
        chk("rst_b_len",    b_len,    0);
        chk("rst_b_status", b_status, 0);
        chk("rst_b_full",   b_full,   0);
        chk("rst_b_empty",  b_empty,  1);
        chk("rst_b_af",     b_af,     0);

        // Single word
        send_word(0, 16'h00AB, 8, 1'b0);
        chk("one_len",    a_len,    1);
        chk("one_data",   a_dout,   8'hAB);
        chk("one_empty",  a_empty,  0);
        chk("one_status", a_status, 0);
        pop(0);
        chk("one_pop_len", a_len, 0);

        // Fill to full, then a pending word stalls
        for (int i = 0; i < 8; i++) send_word(0, 16'h00AB, 8, 1'b0);
        chk("fill_len",  a_len,  8);
        chk("fill_full", a_full, 1);
        chk("fill_af",   a_af,   1);
        send_word(0, 16'h00CC, 8, 1'b0);
        cyc(); cyc();
        chk("stall_status", a_status, 1);
        chk("stall_len",    a_len,    8);
        pop(0);
        chk("swap_status", a_status, 0);
        chk("swap_len",    a_len,    8);
        chk("swap_head",   a_dout,   8'hAB);
        for (int i = 0; i < 7; i++) begin
            chk("drain_head", a_dout, 8'hAB);
            pop(0);
            chk("drain_len", a_len, 7 - i);
            chk("drain_af",  a_af,  ((7 - i) >= 7) ? 1 : 0);
            chk("drain_full", a_full, 0);
        end
        chk("drain_last", a_dout, 8'hCC);
        pop(0);
        chk("drain_empty", a_empty, 1);

        // Dequeue while empty
        drive(0, 1'b0, 1'b0, 1'b1);
        cyc(); cyc(); cyc();
        drive(0, 1'b0, 1'b0, 1'b0);
        chk("under_len",   a_len,   0);
        chk("under_data",  a_dout,  0);
        chk("under_empty", a_empty, 1);
        send_word(0, 16'h0012, 8, 1'b0);
        chk("under_next", a_dout, 8'h12);
        chk("under_nlen", a_len,  1);
        pop(0);

        // Reset in the middle of a word
        send_bits(0, 16'h0007, 3, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst_len", a_len, 0);
        send_word(0, 16'h005A, 8, 1'b0);
        chk("midrst_wlen",  a_len,  1);
        chk("midrst_wdata", a_dout, 8'h5A);

        // Push and pop on the same edge, not full
        send_word(0, 16'h0077, 8, 1'b1);
        chk("pp_len",  a_len,  1);
        chk("pp_data", a_dout, 8'h77);
        pop(0);

        // Wide/shallow instance
        send_word(1, 16'hBEEF, 16, 1'b0);
        send_word(1, 16'h1234, 16, 1'b0);
        chk("w_af_below", b_af, 0);
        send_word(1, 16'hCAFE, 16, 1'b0);
        chk("w_len",  b_len,  3);
        chk("w_af",   b_af,   1);
        chk("w_full", b_full, 0);
        chk("w_pop0", b_dout, 16'hBEEF);
        pop(1);
        chk("w_pop1", b_dout, 16'h1234);
        pop(1);
        chk("w_pop2", b_dout, 16'hCAFE);
        pop(1);
        chk("w_empty", b_empty, 1);

`ifdef DESER_PARITY_EN
        chk("par_start_len", a_len, 0);
        send_bits(0, 16'h000F, 8, 1'b0);
        send_bits(0, 16'h0000, 1, 1'b0);
        chk("par_ok_len",  a_len,  1);
        chk("par_ok_data", a_dout, 8'h0F);
        chk("par_ok_err",  a_perr, 0);
        send_bits(0, 16'h000F, 8, 1'b0);
        drive(0, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("par_bad_err", a_perr, 1);
        drive(0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("par_bad_clr", a_perr, 0);
        cyc(); cyc();
        chk("par_bad_len", a_len, 1);
        chk("par_b_err",   b_perr, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
